// File: rtl/nbody_pkg.sv
// Shared regfile layout, body capacity and sequencer state type
// for the N-body step datapath.
package nbody_pkg;

    localparam int MAX_BODIES = 10;

    localparam int OFFSET_G     = 0;
    localparam int OFFSET_NUM   = 1;
    localparam int OFFSET_START = 2;
    localparam int OFFSET_DONE  = 3;
    localparam int OFFSET_MASS  = 3;
    localparam int OFFSET_RAD   = 13;
    localparam int OFFSET_POS_X = 23;
    localparam int OFFSET_POS_Y = 33;
    localparam int OFFSET_POS_Z = 43;
    localparam int OFFSET_VEL_X = 53;
    localparam int OFFSET_VEL_Y = 63;
    localparam int OFFSET_VEL_Z = 73;
    localparam int OFFSET_ACC_X = 83;
    localparam int OFFSET_ACC_Y = 93;
    localparam int OFFSET_ACC_Z = 103;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_CLEAR       = 3'd1,
        S_PAIRS       = 3'd2,
        S_PAIR_DRAIN  = 3'd3,
        S_INTEG       = 3'd4,
        S_INTEG_DRAIN = 3'd5,
        S_FINISH      = 3'd6
    } seq_state_t;

endpackage

// File: rtl/nbody_step_sequencer_pair_index_gen.sv
// Nested (i,j) counter over unordered body pairs; in single mode
// it walks one index 0..n-1 for the integration phase.
module pair_index_gen
    import nbody_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_single,
    input  logic             i_adv,
    input  logic [IDX_W:0]   i_n,
    output logic [IDX_W-1:0] o_i,
    output logic [IDX_W-1:0] o_j,
    output logic             o_first,
    output logic             o_last
);

    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;
    logic             r_single;
    logic [IDX_W:0]   w_nm1;
    logic [IDX_W:0]   w_nm2;
    logic             w_j_end;

    assign w_nm1   = i_n - (IDX_W+1)'(1);
    assign w_nm2   = i_n - (IDX_W+1)'(2);
    assign w_j_end = ({1'b0, r_j} == w_nm1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_i      <= '0;
            r_j      <= '0;
            r_single <= 1'b0;
        end else if (i_load) begin
            r_i      <= '0;
            r_j      <= i_single ? '0 : IDX_W'(1);
            r_single <= i_single;
        end else if (i_adv) begin
            if (r_single) begin
                r_i <= r_i + IDX_W'(1);
            end else if (w_j_end) begin
                r_i <= r_i + IDX_W'(1);
                r_j <= r_i + IDX_W'(2);
            end else begin
                r_j <= r_j + IDX_W'(1);
            end
        end
    end

    assign o_i     = r_i;
    assign o_j     = r_j;
    assign o_first = (r_i == '0) && (r_single || (r_j == IDX_W'(1)));
    assign o_last  = r_single ? ({1'b0, r_i} == w_nm1)
                              : (({1'b0, r_i} == w_nm2) && w_j_end);

endmodule

// File: rtl/nbody_step_sequencer.sv
// One simulation step: clear accelerations, stream all body pairs
// to the force datapath, then stream every body to the integrator.
module nbody_step_sequencer
    import nbody_pkg::*;
#(
    parameter int MAX_BODIES = nbody_pkg::MAX_BODIES,
    parameter int IDX_W      = 4,
    parameter int ADDR_W     = 7
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [6:0]        NUM_BODIES,
    output logic              BUSY,
    output logic              DONE,
    output logic              CLEAR_ACCS,
    output logic              PAIR_VALID,
    input  logic              PAIR_READY,
    output logic [IDX_W-1:0]  PAIR_I,
    output logic [IDX_W-1:0]  PAIR_J,
    output logic              INTEG_VALID,
    input  logic              INTEG_READY,
    output logic [IDX_W-1:0]  INTEG_IDX,
    input  logic              DP_IDLE,
    output logic [ADDR_W-1:0] ADDR_POS_I,
    output logic [ADDR_W-1:0] ADDR_POS_J,
    output logic [15:0]       STEP_COUNT
);

    localparam int NW = IDX_W + 1;

    localparam logic [2:0] ST_IDLE        = S_IDLE;
    localparam logic [2:0] ST_CLEAR       = S_CLEAR;
    localparam logic [2:0] ST_PAIRS       = S_PAIRS;
    localparam logic [2:0] ST_PAIR_DRAIN  = S_PAIR_DRAIN;
    localparam logic [2:0] ST_INTEG       = S_INTEG;
    localparam logic [2:0] ST_INTEG_DRAIN = S_INTEG_DRAIN;
    localparam logic [2:0] ST_FINISH      = S_FINISH;

    localparam logic [ADDR_W-1:0] POS_BASE = ADDR_W'(OFFSET_POS_X + 1);

    logic [2:0]       r_state;
    logic [NW-1:0]    r_n;
    logic             r_done;
    logic [15:0]      r_step_cnt;
    logic             r_addr_vld;
    logic [NW-1:0]    w_n_req;
    logic             w_load;
    logic             w_single;
    logic             w_adv;
    logic             w_first;
    logic             w_last;
    logic             w_addr_en;
    logic [IDX_W-1:0] w_i;
    logic [IDX_W-1:0] w_j;

    assign w_n_req = (NUM_BODIES > 7'(MAX_BODIES)) ? NW'(MAX_BODIES)
                                                   : NW'(NUM_BODIES);

    // Generator is reloaded for pairs in CLEAR and for single
    // indices while draining the force pipeline.
    assign w_load   = (r_state == ST_CLEAR) || (r_state == ST_PAIR_DRAIN);
    assign w_single = (r_state == ST_PAIR_DRAIN) || (r_n < NW'(2));
    assign w_adv    = ((r_state == ST_PAIRS) && PAIR_READY)
                   || ((r_state == ST_INTEG) && INTEG_READY);

    pair_index_gen #(
        .IDX_W(IDX_W)
    ) u_gen (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_load  (w_load),
        .i_single(w_single),
        .i_adv   (w_adv),
        .i_n     (r_n),
        .o_i     (w_i),
        .o_j     (w_j),
        .o_first (w_first),
        .o_last  (w_last)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_n        <= '0;
            r_done     <= 1'b0;
            r_step_cnt <= '0;
            r_addr_vld <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_state <= ST_CLEAR;
                        r_n     <= w_n_req;
                        r_done  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (r_n >= NW'(2))
                        r_state <= ST_PAIRS;
                    else if (r_n == NW'(1))
                        r_state <= ST_INTEG;
                    else
                        r_state <= ST_FINISH;
                end
                ST_PAIRS: begin
                    if (w_first)
                        r_addr_vld <= 1'b1;
                    if (PAIR_READY && w_last)
                        r_state <= ST_PAIR_DRAIN;
                end
                ST_PAIR_DRAIN: begin
                    if (DP_IDLE)
                        r_state <= ST_INTEG;
                end
                ST_INTEG: begin
                    if (INTEG_READY && w_last)
                        r_state <= ST_INTEG_DRAIN;
                end
                ST_INTEG_DRAIN: begin
                    if (DP_IDLE)
                        r_state <= ST_FINISH;
                end
                ST_FINISH: begin
                    r_done     <= 1'b1;
                    r_step_cnt <= r_step_cnt + 16'd1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Addresses read as zero until the first pair of a step is offered.
    assign w_addr_en = r_addr_vld || (r_state == ST_PAIRS);

    assign BUSY        = (r_state != ST_IDLE);
    assign DONE        = r_done;
    assign CLEAR_ACCS  = (r_state == ST_CLEAR);
    assign PAIR_VALID  = (r_state == ST_PAIRS);
    assign INTEG_VALID = (r_state == ST_INTEG);
    assign PAIR_I      = w_i;
    assign PAIR_J      = w_j;
    assign INTEG_IDX   = w_i;
    assign STEP_COUNT  = r_step_cnt;
    assign ADDR_POS_I  = w_addr_en ? POS_BASE + ADDR_W'(w_i) : '0;
    assign ADDR_POS_J  = w_addr_en ? POS_BASE + ADDR_W'(w_j) : '0;

endmodule

// File: tb/tb_nbody_step_sequencer.sv
// Bench for nbody_step_sequencer: queue-based step model checked
// every cycle, directed scenarios plus randomized steps.
module tb_nbody_step_sequencer;

    localparam int IDX_W  = 4;
    localparam int ADDR_W = 7;

    localparam int P_IDLE   = 0;
    localparam int P_CLEAR  = 1;
    localparam int P_PAIRS  = 2;
    localparam int P_PDRAIN = 3;
    localparam int P_INTEG  = 4;
    localparam int P_IDRAIN = 5;
    localparam int P_FINISH = 6;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              START = 1'b0;
    logic [6:0]        NUM_BODIES = '0;
    logic              PAIR_READY = 1'b0;
    logic              INTEG_READY = 1'b0;
    logic              DP_IDLE = 1'b1;
    logic              BUSY, DONE, CLEAR_ACCS;
    logic              PAIR_VALID, INTEG_VALID;
    logic [IDX_W-1:0]  PAIR_I, PAIR_J, INTEG_IDX;
    logic [ADDR_W-1:0] ADDR_POS_I, ADDR_POS_J;
    logic [15:0]       STEP_COUNT;

    int checks = 0;
    int errors = 0;

    always #10 CLK = ~CLK;

    nbody_step_sequencer dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .NUM_BODIES (NUM_BODIES),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .CLEAR_ACCS (CLEAR_ACCS),
        .PAIR_VALID (PAIR_VALID),
        .PAIR_READY (PAIR_READY),
        .PAIR_I     (PAIR_I),
        .PAIR_J     (PAIR_J),
        .INTEG_VALID(INTEG_VALID),
        .INTEG_READY(INTEG_READY),
        .INTEG_IDX  (INTEG_IDX),
        .DP_IDLE    (DP_IDLE),
        .ADDR_POS_I (ADDR_POS_I),
        .ADDR_POS_J (ADDR_POS_J),
        .STEP_COUNT (STEP_COUNT)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: step phases plus queues of outstanding work.
    int m_phase = P_IDLE;
    int m_n = 0;
    int m_cnt = 0;
    bit m_done = 0;
    bit m_zero = 0;
    bit m_armed = 0;
    int pq[$];
    int iq[$];

    int rec_p[$];
    int rec_pcyc[$];
    int rec_i[$];
    int cyc = 0;
    int start_cyc, clear_cyc, done_cyc, first_iv_cyc;
    int clear_cnt, pv_cnt, iv_cnt, hs_p, hs_i, stall02_cnt;
    int addr02_i, addr02_j;

    always @(negedge CLK) begin
        cyc++;
        if (m_armed) begin
            chk("busy", BUSY, m_phase != P_IDLE);
            chk("clear_accs", CLEAR_ACCS, m_phase == P_CLEAR);
            chk("pair_valid", PAIR_VALID, m_phase == P_PAIRS);
            chk("integ_valid", INTEG_VALID, m_phase == P_INTEG);
            chk("done", DONE, m_done);
            chk("step_count", STEP_COUNT, m_cnt);
            if (m_phase == P_PAIRS && pq.size() > 0) begin
                chk("pair_i", PAIR_I, pq[0] / 16);
                chk("pair_j", PAIR_J, pq[0] % 16);
                chk("addr_pos_i", ADDR_POS_I, 24 + pq[0] / 16);
                chk("addr_pos_j", ADDR_POS_J, 24 + pq[0] % 16);
                pv_cnt++;
                if (pq[0] == 2) begin
                    stall02_cnt++;
                    addr02_i = ADDR_POS_I;
                    addr02_j = ADDR_POS_J;
                end
            end
            if (m_phase == P_INTEG && iq.size() > 0) begin
                chk("integ_idx", INTEG_IDX, iq[0]);
                iv_cnt++;
                if (first_iv_cyc < 0) first_iv_cyc = cyc;
            end
            if (m_zero) begin
                chk("zero_pair_i", PAIR_I, 0);
                chk("zero_pair_j", PAIR_J, 0);
                chk("zero_integ_idx", INTEG_IDX, 0);
                chk("zero_addr_i", ADDR_POS_I, 0);
                chk("zero_addr_j", ADDR_POS_J, 0);
            end
            if (CLEAR_ACCS) begin
                clear_cnt++;
                clear_cyc = cyc;
            end
            if (PAIR_VALID && PAIR_READY) hs_p++;
            if (INTEG_VALID && INTEG_READY) hs_i++;
        end
        if (RESET) begin
            m_armed = 1;
            m_phase = P_IDLE;
            m_done  = 0;
            m_cnt   = 0;
            m_zero  = 1;
            pq.delete();
            iq.delete();
        end else if (m_armed) begin
            case (m_phase)
                P_IDLE: if (START) begin
                    m_n = (NUM_BODIES > 10) ? 10 : int'(NUM_BODIES);
                    pq.delete();
                    iq.delete();
                    for (int i = 0; i < m_n - 1; i++)
                        for (int j = i + 1; j < m_n; j++)
                            pq.push_back(i * 16 + j);
                    for (int k = 0; k < m_n; k++) iq.push_back(k);
                    m_done = 0;
                    m_zero = 0;
                    m_phase = P_CLEAR;
                    start_cyc = cyc;
                end
                P_CLEAR: m_phase = (m_n >= 2) ? P_PAIRS
                                 : (m_n == 1) ? P_INTEG : P_FINISH;
                P_PAIRS: if (PAIR_READY && pq.size() > 0) begin
                    rec_p.push_back(pq[0]);
                    rec_pcyc.push_back(cyc);
                    void'(pq.pop_front());
                    if (pq.size() == 0) m_phase = P_PDRAIN;
                end
                P_PDRAIN: if (DP_IDLE) m_phase = P_INTEG;
                P_INTEG: if (INTEG_READY && iq.size() > 0) begin
                    rec_i.push_back(iq[0]);
                    void'(iq.pop_front());
                    if (iq.size() == 0) m_phase = P_IDRAIN;
                end
                P_IDRAIN: if (DP_IDLE) m_phase = P_FINISH;
                P_FINISH: begin
                    m_done = 1;
                    m_cnt = (m_cnt + 1) % 65536;
                    m_phase = P_IDLE;
                    done_cyc = cyc + 1;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    int rdy_mode = 0;
    int dp_mode = 0;
    int stall_left = 0;

    task automatic drive_cycle(input bit noise);
        @(posedge CLK);
        #1;
        case (rdy_mode)
            1: begin
                PAIR_READY  = ($urandom_range(0, 3) != 0);
                INTEG_READY = ($urandom_range(0, 3) != 0);
            end
            2: begin
                if (PAIR_VALID && PAIR_I == 0 && PAIR_J == 2 && stall_left > 0) begin
                    PAIR_READY = 1'b0;
                    stall_left--;
                end else begin
                    PAIR_READY = 1'b1;
                end
                INTEG_READY = 1'b1;
            end
            default: begin
                PAIR_READY  = 1'b1;
                INTEG_READY = 1'b1;
            end
        endcase
        if (dp_mode == 1) DP_IDLE = ($urandom_range(0, 2) != 0);
        if (noise) begin
            START = ($urandom_range(0, 4) == 0);
            NUM_BODIES = 7'($urandom);
        end
    endtask

    task automatic clear_rec();
        rec_p.delete();
        rec_pcyc.delete();
        rec_i.delete();
        clear_cnt = 0;
        pv_cnt = 0;
        iv_cnt = 0;
        hs_p = 0;
        hs_i = 0;
        stall02_cnt = 0;
        first_iv_cyc = -1;
    endtask

    task automatic launch(input int nb);
        clear_rec();
        @(posedge CLK);
        #1;
        START = 1'b1;
        NUM_BODIES = 7'(nb);
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input bit noise);
        int guard = 0;
        while (!DONE && guard < 3000) begin
            drive_cycle(noise);
            if (DONE) START = 1'b0;
            guard++;
        end
        START = 1'b0;
        chk("step_timeout", guard < 3000, 1);
    endtask

    task automatic run_step(input int nb, input bit noise);
        launch(nb);
        wait_done(noise);
    endtask

    initial begin
        int g;
        int nn;
        int base;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_step_count", STEP_COUNT, 0);
        chk("rst_addr_i", ADDR_POS_I, 0);

        // n=4, always ready
        rdy_mode = 0;
        dp_mode = 0;
        run_step(4, 0);
        chk("n4_pairs", rec_p.size(), 6);
        if (rec_p.size() == 6) begin
            chk("n4_p0", rec_p[0], 8'h01);
            chk("n4_p1", rec_p[1], 8'h02);
            chk("n4_p2", rec_p[2], 8'h03);
            chk("n4_p3", rec_p[3], 8'h12);
            chk("n4_p4", rec_p[4], 8'h13);
            chk("n4_p5", rec_p[5], 8'h23);
            chk("n4_back_to_back", rec_pcyc[5] - rec_pcyc[0], 5);
            chk("n4_drain_gap", first_iv_cyc - rec_pcyc[5], 2);
        end
        chk("n4_hs_pairs", hs_p, 6);
        chk("n4_integ", rec_i.size(), 4);
        if (rec_i.size() == 4) chk("n4_integ_last", rec_i[3], 3);
        chk("n4_clear_cnt", clear_cnt, 1);
        chk("n4_clear_delay", clear_cyc - start_cyc, 1);
        chk("n4_done", DONE, 1);
        chk("n4_step_count", STEP_COUNT, 1);

        // n=3, pair (0,2) stalled for 3 cycles
        rdy_mode = 2;
        stall_left = 3;
        run_step(3, 0);
        chk("n3_pairs", rec_p.size(), 3);
        if (rec_p.size() == 3) begin
            chk("n3_p0", rec_p[0], 8'h01);
            chk("n3_p1", rec_p[1], 8'h02);
            chk("n3_p2", rec_p[2], 8'h12);
        end
        chk("n3_hs_pairs", hs_p, 3);
        chk("n3_hold_cycles", stall02_cnt, 4);
        chk("n3_addr_i", addr02_i, 24);
        chk("n3_addr_j", addr02_j, 26);
        chk("n3_step_count", STEP_COUNT, 2);

        // n=0
        rdy_mode = 0;
        run_step(0, 0);
        chk("n0_pair_valid_cycles", pv_cnt, 0);
        chk("n0_integ_valid_cycles", iv_cnt, 0);
        chk("n0_done_delay", done_cyc - start_cyc, 3);
        chk("n0_clear_cnt", clear_cnt, 1);

        // n=1
        run_step(1, 0);
        chk("n1_pairs", hs_p, 0);
        chk("n1_integ", hs_i, 1);
        if (rec_i.size() == 1) chk("n1_idx", rec_i[0], 0);

        // clamp 15 -> 10
        rdy_mode = 1;
        run_step(15, 0);
        chk("n15_pairs", hs_p, 45);
        chk("n15_integ", hs_i, 10);
        if (rec_p.size() == 45) chk("n15_last_pair", rec_p[44], 8'h89);

        // reset during PAIRS
        launch(5);
        g = 0;
        while (rec_p.size() < 2 && g < 200) begin
            drive_cycle(0);
            g++;
        end
        chk("rst_mid_reach_pairs", rec_p.size() >= 2, 1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("rst_mid_busy", BUSY, 0);
        chk("rst_mid_pair_valid", PAIR_VALID, 0);
        chk("rst_mid_clear", CLEAR_ACCS, 0);
        chk("rst_mid_done", DONE, 0);
        chk("rst_mid_step_count", STEP_COUNT, 0);
        chk("rst_mid_pair_j", PAIR_J, 0);

        rdy_mode = 0;
        run_step(2, 0);
        chk("post_rst_pairs", hs_p, 1);
        if (rec_p.size() == 1) chk("post_rst_p0", rec_p[0], 8'h01);
        chk("post_rst_integ", hs_i, 2);
        chk("post_rst_step_count", STEP_COUNT, 1);

        // DP_IDLE low for 5 drain cycles
        DP_IDLE = 1'b0;
        PAIR_READY = 1'b1;
        INTEG_READY = 1'b1;
        launch(2);
        g = 0;
        while (!PAIR_VALID && g < 20) begin
            @(posedge CLK);
            #1;
            g++;
        end
        chk("drain_reach_pairs", PAIR_VALID, 1);
        @(posedge CLK);
        #1;
        repeat (5) begin
            @(posedge CLK);
            #1;
        end
        DP_IDLE = 1'b1;
        wait_done(0);
        if (rec_pcyc.size() == 1)
            chk("drain_delay", first_iv_cyc - rec_pcyc[0], 7);
        chk("drain_step_count", STEP_COUNT, 2);

        // randomized steps with stray START / NUM_BODIES activity
        rdy_mode = 1;
        dp_mode = 1;
        base = STEP_COUNT;
        for (int k = 0; k < 8; k++) begin
            nn = $urandom_range(0, 15);
            run_step(nn, 1);
            if (nn > 10) nn = 10;
            chk("rand_pairs", hs_p, nn * (nn - 1) / 2);
            chk("rand_integ", hs_i, nn);
            chk("rand_step_count", STEP_COUNT, base + k + 1);
        end
        dp_mode = 0;
        DP_IDLE = 1'b1;
        repeat (3) @(posedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nbody_step_sequencer.md
Name: nbody_step_sequencer

Overview:
- Sequences one N-body simulation step over the shared body register file: clear accelerations, issue every unordered body pair to the force datapath, then issue every body to the integrator.
- Sits between the Avalon-mapped control words (START, body count, DONE) and the physics datapath.
- Replaces ad-hoc pair looping in the physics FSM with a valid/ready index stream plus regfile address generation.

Parameters:
- MAX_BODIES, 10, capacity of each per-body regfile array.
- IDX_W, 4, width of body index (must satisfy 2^IDX_W >= MAX_BODIES).
- ADDR_W, 7, regfile word-address width.

Ports:
- CLK, in, 1, system clock (50 MHz).
- RESET, in, 1, synchronous active-high reset.
- START, in, 1, step request; sampled only in IDLE.
- NUM_BODIES, in, 7, requested body count; latched on accepted START.
- BUSY, out, 1, high from the cycle after START is accepted until FINISH.
- DONE, out, 1, sticky step-complete flag.
- CLEAR_ACCS, out, 1, one-cycle pulse that zeroes the acceleration arrays.
- PAIR_VALID, out, 1, pair (PAIR_I, PAIR_J) is offered.
- PAIR_READY, in, 1, datapath accepts the pair.
- PAIR_I, out, IDX_W, first body index.
- PAIR_J, out, IDX_W, second body index.
- INTEG_VALID, out, 1, body INTEG_IDX is offered for integration.
- INTEG_READY, in, 1, integrator accepts the body.
- INTEG_IDX, out, IDX_W, body index to integrate.
- DP_IDLE, in, 1, datapath has no operations in flight.
- ADDR_POS_I, out, ADDR_W, OFFSET_POS_X+1+PAIR_I; Y and Z addresses are this value +10 and +20.
- ADDR_POS_J, out, ADDR_W, OFFSET_POS_X+1+PAIR_J.
- STEP_COUNT, out, 16, completed-step counter.

Behaviour:
- Reset values: all outputs 0. State is IDLE. Latched count n is 0.
- Clock and reset: single clock CLK; RESET is synchronous, active-high.
- Count latch: n = min(NUM_BODIES, MAX_BODIES), captured on the accepting edge.
- States: IDLE, CLEAR, PAIRS, PAIR_DRAIN, INTEG, INTEG_DRAIN, FINISH.
- IDLE:
  - START=1 at edge k → CLEAR in cycle k+1.
  - DONE clears at the same edge.
  - BUSY=1 from cycle k+1.
- CLEAR: CLEAR_ACCS=1 for exactly this one cycle, then:
  - PAIRS if n>=2;
  - INTEG if n==1;
  - FINISH if n==0.
- PAIRS:
  - Order is i=0..n-2, j=i+1..n-1, starting at (0,1).
  - PAIR_VALID stays high and indices stay stable until PAIR_READY=1 in the same cycle.
  - After a handshake the next pair is offered in the following cycle, so zero-bubble back-to-back issue is possible.
  - Handshake on the last pair (n-2, n-1) → PAIR_DRAIN. PAIR_VALID=0 there.
  - Total pairs = n(n-1)/2.
- PAIR_DRAIN: stay until DP_IDLE=1 is sampled, then → INTEG. Minimum one cycle in this state.
- INTEG: idx 0..n-1 under the same valid/ready rules as PAIRS. Handshake on idx n-1 → INTEG_DRAIN.
- INTEG_DRAIN: wait for DP_IDLE=1, then → FINISH.
- FINISH (one cycle):
  - DONE←1, BUSY←0, STEP_COUNT←STEP_COUNT+1 (wraps 0xFFFF→0).
  - Next state is IDLE.
  - START high during FINISH is ignored; it is accepted in IDLE on the next cycle.
- START outside IDLE is ignored. NUM_BODIES changes mid-step have no effect.
- When VALID is low: indices and addresses hold their last values and are don't-care to consumers. READY is ignored.
- RESET mid-step:
  - Next cycle is IDLE with all outputs 0, including DONE and STEP_COUNT.
  - No CLEAR_ACCS pulse.
  - In-flight datapath operations are the datapath's responsibility.
- Address arithmetic: modulo 2^ADDR_W, unsigned. With MAX_BODIES=10, the maximum address is 23+1+9+20=53, so no overflow occurs.

Decomposition:
- Package nbody_pkg holds:
  - regfile offsets OFFSET_G, OFFSET_NUM, OFFSET_START, OFFSET_DONE, OFFSET_MASS, OFFSET_RAD, OFFSET_POS_X/Y/Z, OFFSET_VEL_X/Y/Z, OFFSET_ACC_X/Y/Z;
  - MAX_BODIES;
  - enum seq_state_t.
- Sub-module pair_index_gen: the (i,j) nested counter with advance input, plus first/last flags. It is reused for the integration phase in single-index mode.

Test Plan:
- n=4, READY tied high:
  - CLEAR_ACCS pulses once, one cycle after START.
  - Pairs appear on consecutive cycles: (0,1),(0,2),(0,3),(1,2),(1,3),(2,3).
  - Then idx 0..3.
  - DONE=1, STEP_COUNT=1.
- n=3, PAIR_READY low for 3 cycles on pair (0,2):
  - Indices hold (0,2) with VALID high throughout; no pair is skipped or duplicated.
  - ADDR_POS_I=24, ADDR_POS_J=26.
- n=0:
  - CLEAR → FINISH: no VALID ever asserted, DONE set 3 cycles after START.
- n=1:
  - No pairs; a single INTEG idx 0.
- NUM_BODIES=15:
  - Clamped to 10: 45 pairs, then 10 integrations.
- Reset and drain:
  - RESET asserted during PAIRS → all outputs 0 next cycle.
  - A later START with n=2 completes normally.
  - Holding DP_IDLE=0 for 5 cycles in PAIR_DRAIN delays INTEG_VALID by exactly 5 cycles.
